// File: rtl/sound_synth_n_if.sv
// sound_synth_n_if -- register-write and sample bus for the sound synthesiser.
//
// Signals:
//   wen       write strobe, one register write per asserted cycle
//   ch_sel    target channel of the write
//   ch_param  target field: 0 period, 1 volume, 2 width, 3 decay, 4 mode, 5 key-on
//   ch_val    write data, low bits used per field width
//   tick      envelope timebase strobe, one cycle wide
//   sample    registered, unsigned mixed output
//
// master: the controller driving writes/ticks and consuming samples.
// slave : the synthesiser.
interface sound_synth_n_if #(
   parameter int NCH = 4,
   parameter int SW  = 24
);
   localparam int CW = $clog2(NCH);

   logic          wen;
   logic [CW-1:0] ch_sel;
   logic [2:0]    ch_param;
   logic [15:0]   ch_val;
   logic          tick;
   logic [SW-1:0] sample;

   modport master (
      output wen, ch_sel, ch_param, ch_val, tick,
      input  sample
   );

   modport slave (
      input  wen, ch_sel, ch_param, ch_val, tick,
      output sample
   );
endinterface

// File: rtl/sound_synth_n.sv
// sound_synth_n -- NCH-channel pulse/noise tone synthesiser with decaying
// envelopes, mixed into a single registered unsigned sample.
//
// Ports:
//   clk     clock, all state changes on the rising edge
//   resetn  synchronous active-low reset
//   bus     sound_synth_n_if.slave: register writes (wen/ch_sel/ch_param/ch_val),
//           envelope tick, and the mixed sample output
//
// Each channel steps through 8 steps of `period` clocks each. Pulse mode gates
// on step <= width; noise mode gates on the LFSR LSB, shifted once per step.
// The envelope level is loaded from volume on key-on and decays by one every
// `decay` ticks.
module sound_synth_n #(
   parameter int NCH = 4,
   parameter int PW  = 16,
   parameter int VW  = 5,
   parameter int SW  = 24
) (
   input logic              clk,
   input logic              resetn,
   sound_synth_n_if.slave   bus
);

   localparam int CW    = $clog2(NCH);
   localparam int MW    = VW + CW;
   localparam int SHIFT = SW - MW;

   typedef enum logic [2:0] {
      PAR_PERIOD = 3'd0,
      PAR_VOLUME = 3'd1,
      PAR_WIDTH  = 3'd2,
      PAR_DECAY  = 3'd3,
      PAR_MODE   = 3'd4,
      PAR_KEYON  = 3'd5
   } param_e;

   logic [PW-1:0] period_q [NCH];
   logic [PW-1:0] period_d [NCH];
   logic [VW-1:0] volume_q [NCH];
   logic [VW-1:0] volume_d [NCH];
   logic [2:0]    width_q  [NCH];
   logic [2:0]    width_d  [NCH];
   logic [7:0]    decay_q  [NCH];
   logic [7:0]    decay_d  [NCH];
   logic          mode_q   [NCH];
   logic          mode_d   [NCH];
   logic [VW-1:0] level_q  [NCH];
   logic [VW-1:0] level_d  [NCH];
   logic [PW-1:0] phase_q  [NCH];
   logic [PW-1:0] phase_d  [NCH];
   logic [2:0]    step_q   [NCH];
   logic [2:0]    step_d   [NCH];
   logic [14:0]   lfsr_q   [NCH];
   logic [14:0]   lfsr_d   [NCH];
   logic [7:0]    presc_q  [NCH];
   logic [7:0]    presc_d  [NCH];

   logic [NCH-1:0] hit;
   logic [NCH-1:0] wrap;
   logic [NCH-1:0] gate;
   logic [VW-1:0]  chan_out [NCH];
   logic [MW-1:0]  mix;
   logic [SW-1:0]  sample_q;
   logic [SW-1:0]  sample_d;

   // Per-channel next state. Free-running phase/envelope updates are computed
   // first; a register write to the channel is applied last so it takes
   // precedence (a period write discards a coincident wrap entirely).
   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         period_d[i] = period_q[i];
         volume_d[i] = volume_q[i];
         width_d[i]  = width_q[i];
         decay_d[i]  = decay_q[i];
         mode_d[i]   = mode_q[i];
         level_d[i]  = level_q[i];
         phase_d[i]  = phase_q[i];
         step_d[i]   = step_q[i];
         lfsr_d[i]   = lfsr_q[i];
         presc_d[i]  = presc_q[i];

         hit[i]  = bus.wen && (bus.ch_sel == CW'(i));
         wrap[i] = (period_q[i] != '0) && (phase_q[i] == period_q[i] - PW'(1));

         // Phase accumulator / step sequencer; period 0 parks the channel.
         if (period_q[i] == '0) begin
            phase_d[i] = '0;
            step_d[i]  = '0;
         end else if (wrap[i]) begin
            phase_d[i] = '0;
            step_d[i]  = step_q[i] + 3'd1;
            if (mode_q[i]) begin
               lfsr_d[i] = {lfsr_q[i][0] ^ lfsr_q[i][1], lfsr_q[i][14:1]};
            end
         end else begin
            phase_d[i] = phase_q[i] + PW'(1);
         end

         // Envelope: key-on beats a coincident tick.
         if (hit[i] && (bus.ch_param == PAR_KEYON)) begin
            level_d[i] = volume_q[i];
            presc_d[i] = '0;
         end else if (bus.tick && (decay_q[i] != '0)) begin
            if (presc_q[i] == decay_q[i] - 8'd1) begin
               presc_d[i] = '0;
               if (level_q[i] != '0) begin
                  level_d[i] = level_q[i] - VW'(1);
               end
            end else begin
               presc_d[i] = presc_q[i] + 8'd1;
            end
         end

         if (hit[i]) begin
            case (bus.ch_param)
               PAR_PERIOD: begin
                  period_d[i] = bus.ch_val[PW-1:0];
                  phase_d[i]  = '0;
                  step_d[i]   = '0;
                  lfsr_d[i]   = lfsr_q[i];
               end
               PAR_VOLUME: volume_d[i] = bus.ch_val[VW-1:0];
               PAR_WIDTH:  width_d[i]  = bus.ch_val[2:0];
               PAR_DECAY:  decay_d[i]  = bus.ch_val[7:0];
               PAR_MODE:   mode_d[i]   = bus.ch_val[0];
               default: ;
            endcase
         end
      end
   end

   // Channel gating and mix.
   always_comb begin
      mix = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         gate[i]     = mode_q[i] ? lfsr_q[i][0] : (step_q[i] <= width_q[i]);
         chan_out[i] = (gate[i] && (period_q[i] != '0)) ? level_q[i] : '0;
         mix         = mix + MW'(chan_out[i]);
      end
      sample_d = SW'(mix) << SHIFT;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            period_q[i] <= '1;
            volume_q[i] <= '0;
            width_q[i]  <= '0;
            decay_q[i]  <= '0;
            mode_q[i]   <= 1'b0;
            level_q[i]  <= '0;
            phase_q[i]  <= '0;
            step_q[i]   <= '0;
            lfsr_q[i]   <= 15'h7FFF;
            presc_q[i]  <= '0;
         end
         sample_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            period_q[i] <= period_d[i];
            volume_q[i] <= volume_d[i];
            width_q[i]  <= width_d[i];
            decay_q[i]  <= decay_d[i];
            mode_q[i]   <= mode_d[i];
            level_q[i]  <= level_d[i];
            phase_q[i]  <= phase_d[i];
            step_q[i]   <= step_d[i];
            lfsr_q[i]   <= lfsr_d[i];
            presc_q[i]  <= presc_d[i];
         end
         sample_q <= sample_d;
      end
   end

   assign bus.sample = sample_q;

endmodule

// File: doc/sound_synth_n.md
SOUND_SYNTH_N -- requirements
Module: sound_synth_n

Interface
REQ-001 NCH, 4, channel count; power of two, 2..8.
REQ-002 PW, 16, period register width in bits.
REQ-003 VW, 5, volume and envelope level width in bits.
REQ-004 SW, 24, mixed sample width; SW >= VW + log2(NCH).
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 wen  input  1  register write strobe, one write per asserted cycle.
REQ-008 ch_sel  input  log2(NCH)  target channel of the write.
REQ-009 ch_param  input  3  target parameter: 0 period, 1 volume, 2 width, 3 decay, 4 mode, 5 key-on.
REQ-010 ch_val  input  16  write data; low bits used per field width.
REQ-011 tick  input  1  envelope timebase strobe, one cycle wide.
REQ-012 sample  output  SW  registered mixed output, unsigned.

Function
REQ-013 Each channel SHALL hold: period[PW], volume[VW], width[3], decay[8], mode[1], level[VW], phase counter[PW], step[3], lfsr[15], decay prescaler[8].
REQ-014 Write (wen=1) SHALL update only the field selected by ch_param/ch_sel on the next edge; ch_param 6..7 SHALL be ignored.
REQ-015 Period write SHALL also clear that channel's phase counter and step to 0.
REQ-016 Key-on write (ch_val ignored) SHALL load level <= volume and clear the decay prescaler.
REQ-017 Period != 0: phase counter increments every clk; at period-1 it wraps to 0 and step increments mod 8; each step lasts exactly period cycles.
REQ-018 Period == 0: channel muted, phase counter and step held at 0, lfsr held.
REQ-019 Mode 0 (pulse): gate = (step <= width); duty = (width+1)/8; width 7 = constant high.
REQ-020 Mode 1 (noise): on each phase wrap lfsr <= {lfsr[0]^lfsr[1], lfsr[14:1]}; gate = lfsr[0].
REQ-021 Channel output SHALL be level when gate=1, else 0.
REQ-022 Decay 0: level held (sustain).
REQ-023 Decay D>0: each tick increments prescaler; when prescaler reaches D-1 it clears and level decrements, saturating at 0.
REQ-024 Key-on and tick in the same cycle: key-on wins; no decrement that cycle.
REQ-025 Volume write SHALL NOT change level until next key-on.
REQ-026 sample SHALL equal (sum of all channel outputs) << (SW-VW-log2(NCH)), registered: 1 clk latency from channel state to sample; no overflow possible by REQ-004.
REQ-027 Write to a channel in the same cycle as its phase wrap: the write takes effect; period write clear overrides the wrap.

Reset
REQ-028 resetn=0 at an edge SHALL set all channels: period all-ones, volume 0, width 0, decay 0, mode 0, level 0, phase 0, step 0, prescaler 0, lfsr 15'h7FFF; sample 0.
REQ-029 Reset SHALL override wen and tick in the same cycle; mid-waveform reset returns sample to 0 on the next edge.

Verification
REQ-030 ch0 period=4, width=3, volume=31, key-on -> sample 0x3E0000 for 16 clks, then 0 for 16 clks, repeating every 32 clks.
REQ-031 Above plus decay=2, tick every clk -> level decrements every 2 ticks; 31 steps later level 0; sample stays 0, no wrap.
REQ-032 All 4 channels width=7, volume=31, key-on -> sample 0xF80000 steady.
REQ-033 ch1 mode=1, period=1, volume=16, key-on -> gate follows lfsr[0] from 0x7FFF: bit sequence matches reference LFSR model for 100 wraps.
REQ-034 Running tone, resetn=0 for 1 clk -> sample 0 next edge; stays 0 after release until new key-on.
REQ-035 Key-on and tick same cycle with decay=1 -> level equals volume, decrements only on following tick.
